// File: rtl/stack_pkg.sv
// stack_pkg
// Purpose : command encodings shared by the stack arbiter, its requesters
//           and the stack it drives.
// Ports   : none (package).
package stack_pkg;
  localparam logic [2:0] COM_NOP      = 3'd0;
  localparam logic [2:0] COM_PUSH     = 3'd1;
  localparam logic [2:0] COM_POP      = 3'd2;
  localparam logic [2:0] COM_LOAD_PTR = 3'd3;
  localparam logic [2:0] COM_READ_PTR = 3'd4;
endpackage

// File: rtl/stack_arbiter_if.sv
// stack_arbiter_if
// Purpose : requester-side bus of the stack arbiter (two requesters).
// Signals : i_req_valid/i_req_cmd/i_req_data   requests into the arbiter
//           o_req_ready                        one-cycle accept pulse
//           o_rsp_valid/o_rsp_data/o_rsp_err   completion pulse and payload
// Modports: master = requester side, slave = arbiter side.
interface stack_arbiter_if #(
  parameter int DATA_W = 16
);
  logic [1:0]             i_req_valid;
  logic [1:0][2:0]        i_req_cmd;
  logic [1:0][DATA_W-1:0] i_req_data;
  logic [1:0]             o_req_ready;
  logic [1:0]             o_rsp_valid;
  logic [DATA_W-1:0]      o_rsp_data;
  logic                   o_rsp_err;

  modport master (
    output i_req_valid, i_req_cmd, i_req_data,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err
  );

  modport slave (
    input  i_req_valid, i_req_cmd, i_req_data,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err
  );
endinterface

// File: rtl/stack_arbiter.sv
// stack_arbiter
// Purpose : round-robin arbiter letting two requesters share one stack.
//           One operation is in flight at a time: accept (IDLE), drive the
//           stack for one cycle (ISSUE), wait POP_LAT cycles for pop data
//           (WAIT), return a one-cycle response to the owner (RESP).
//           A shadow stack pointer tracks PUSH/POP/LOAD_PTR.
// Ports   : i_Clk, i_Reset_n (async, active low)
//           bus            requester bus (stack_arbiter_if.slave)
//           o_stk_command  command to the stack (COM_NOP when idle)
//           o_stk_data     write data to the stack
//           i_stk_data     stack read data (pop word or pointer)
//           o_sp           shadow stack pointer
//           o_busy         high whenever not IDLE
// Option  : define STACK_ARBITER_GUARD_EN to reject PUSH on a full pointer
//           and POP on an empty one (COM_NOP issued, error response).
module stack_arbiter
  import stack_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int PTR_W   = 8,
  parameter int POP_LAT = 1
) (
  input  logic              i_Clk,
  input  logic              i_Reset_n,
  stack_arbiter_if.slave    bus,
  output logic [2:0]        o_stk_command,
  output logic [DATA_W-1:0] o_stk_data,
  input  logic [DATA_W-1:0] i_stk_data,
  output logic [PTR_W-1:0]  o_sp,
  output logic              o_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        cmd_reg;
  logic [DATA_W-1:0] data_reg;
  logic              owner_reg;
  logic              prio_reg;      // requester that wins a tie
  logic [PTR_W-1:0]  sp_reg;
  logic [DATA_W-1:0] cap_reg;       // response data of the operation in flight
  logic [DATA_W-1:0] last_rsp_reg;  // held on o_rsp_data between pulses
  logic              err_reg;
  logic [1:0]        cnt_reg;

  logic any_req;
  logic grant_idx;
  logic guard_hit;
  logic pop_done;

  assign any_req   = |bus.i_req_valid;
  // Single requester wins outright; on a tie the priority pointer decides.
  assign grant_idx = (bus.i_req_valid == 2'b11) ? prio_reg : bus.i_req_valid[1];
  assign pop_done  = (cnt_reg == 2'(POP_LAT - 1));

`ifdef STACK_ARBITER_GUARD_EN
  assign guard_hit = ((cmd_reg == COM_PUSH) && (sp_reg == {PTR_W{1'b1}})) ||
                     ((cmd_reg == COM_POP)  && (sp_reg == '0));
`else
  assign guard_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) state_reg <= IDLE;
    else            state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (any_req) state_next = ISSUE;
      ISSUE: state_next = ((cmd_reg == COM_POP) && !guard_hit) ? WAIT : RESP;
      WAIT:  if (pop_done) state_next = RESP;
      RESP:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      cmd_reg      <= COM_NOP;
      data_reg     <= '0;
      owner_reg    <= 1'b0;
      prio_reg     <= 1'b0;
      sp_reg       <= '0;
      cap_reg      <= '0;
      last_rsp_reg <= '0;
      err_reg      <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: if (any_req) begin
          cmd_reg   <= bus.i_req_cmd[grant_idx];
          data_reg  <= bus.i_req_data[grant_idx];
          owner_reg <= grant_idx;
          prio_reg  <= ~grant_idx;
          cap_reg   <= '0;
          err_reg   <= 1'b0;
        end
        ISSUE: begin
          cnt_reg <= '0;
          if (guard_hit) begin
            err_reg <= 1'b1;
          end else begin
            case (cmd_reg)
              COM_PUSH:     sp_reg  <= sp_reg + 1'b1;
              COM_POP:      sp_reg  <= sp_reg - 1'b1;
              COM_LOAD_PTR: sp_reg  <= data_reg[PTR_W-1:0];
              COM_READ_PTR: cap_reg <= i_stk_data;
              default: ;
            endcase
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (pop_done) cap_reg <= i_stk_data;
        end
        RESP: last_rsp_reg <= cap_reg;
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    bus.o_req_ready = '0;
    bus.o_rsp_valid = '0;
    bus.o_rsp_data  = last_rsp_reg;
    bus.o_rsp_err   = 1'b0;
    o_stk_command   = COM_NOP;
    o_stk_data      = '0;
    o_busy          = (state_reg != IDLE);
    case (state_reg)
      // Gated by reset so no accept is ever advertised while held in reset.
      IDLE: if (any_req && i_Reset_n) bus.o_req_ready[grant_idx] = 1'b1;
      ISSUE: begin
        o_stk_command = guard_hit ? COM_NOP : cmd_reg;
        o_stk_data    = data_reg;
      end
      RESP: begin
        bus.o_rsp_valid[owner_reg] = 1'b1;
        bus.o_rsp_data             = cap_reg;
        bus.o_rsp_err              = err_reg;
      end
      default: ;
    endcase
  end

  assign o_sp = sp_reg;

endmodule

// File: tb/tb_stack_arbiter.sv
module tb_stack_arbiter;
  import stack_pkg::*;

  localparam int DATA_W  = 16;
  localparam int PTR_W   = 8;
  localparam int POP_LAT = 1;
`ifdef STACK_ARBITER_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              i_Clk;
  logic              i_Reset_n;
  logic [2:0]        o_stk_command;
  logic [DATA_W-1:0] o_stk_data;
  logic [DATA_W-1:0] i_stk_data;
  logic [PTR_W-1:0]  o_sp;
  logic              o_busy;

  stack_arbiter_if #(.DATA_W(DATA_W)) bus();

  stack_arbiter #(.DATA_W(DATA_W), .PTR_W(PTR_W), .POP_LAT(POP_LAT)) dut (
    .i_Clk        (i_Clk),
    .i_Reset_n    (i_Reset_n),
    .bus          (bus),
    .o_stk_command(o_stk_command),
    .o_stk_data   (o_stk_data),
    .i_stk_data   (i_stk_data),
    .o_sp         (o_sp),
    .o_busy       (o_busy)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  // Simple external stack device obeying the command port.
  bit   [15:0] stk_mem [256];
  logic [7:0]  stk_sp;
  logic [15:0] stk_rd;
  always @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      stk_sp <= 8'd0;
      stk_rd <= 16'd0;
    end else begin
      case (o_stk_command)
        COM_PUSH: begin stk_mem[stk_sp] <= o_stk_data; stk_sp <= stk_sp + 8'd1; end
        COM_POP:  begin stk_rd <= stk_mem[stk_sp - 8'd1]; stk_sp <= stk_sp - 8'd1; end
        COM_LOAD_PTR: stk_sp <= o_stk_data[7:0];
        default: ;
      endcase
    end
  end
  assign i_stk_data = (o_stk_command == COM_READ_PTR) ? {8'h00, stk_sp} : stk_rd;

  int total = 0;
  int bad   = 0;

  // Reference model: abstract stack as pointer + word array.
  int        sp_m;
  bit [15:0] mem_m [256];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic model_step(input logic [2:0] cmd, input logic [15:0] data,
                            output logic [15:0] e_data, output logic e_err,
                            output int e_lat, output logic [2:0] e_cmd);
    e_data = 16'h0; e_err = 1'b0; e_lat = 2; e_cmd = cmd;
    case (cmd)
      COM_PUSH:
        if (GUARD && sp_m == 255) begin e_err = 1'b1; e_cmd = COM_NOP; end
        else begin mem_m[sp_m] = data; sp_m = (sp_m + 1) % 256; end
      COM_POP:
        if (GUARD && sp_m == 0) begin e_err = 1'b1; e_cmd = COM_NOP; end
        else begin sp_m = (sp_m + 255) % 256; e_data = mem_m[sp_m]; e_lat = 2 + POP_LAT; end
      COM_LOAD_PTR: sp_m = int'(data) % 256;
      COM_READ_PTR: e_data = 16'(sp_m);
      default: ;
    endcase
  endtask

  // One request from one requester, checked end to end.
  task automatic run_one(input string tag, input int who, input logic [2:0] cmd,
                         input logic [15:0] data, input logic [15:0] e_data,
                         input logic e_err, input logic [7:0] e_sp,
                         input int e_lat, input logic [2:0] e_cmd);
    bit acc;
    int lat;
    @(posedge i_Clk); #2;
    bus.i_req_valid[who] = 1'b1;
    bus.i_req_cmd[who]   = cmd;
    bus.i_req_data[who]  = data;
    acc = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge i_Clk);
      if (bus.o_req_ready[who]) acc = 1'b1;
    end
    chk({tag, "_accept"}, 32'(acc), 32'd1);
    if (!acc) begin
      bus.i_req_valid[who] = 1'b0;
      return;
    end
    @(posedge i_Clk); #1;
    bus.i_req_valid[who] = 1'b0;
    chk({tag, "_stkcmd"}, 32'(o_stk_command), 32'(e_cmd));
    if (e_cmd != COM_NOP) chk({tag, "_stkdata"}, 32'(o_stk_data), 32'(data));
    chk({tag, "_busy"}, 32'(o_busy), 32'd1);
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      if (k > 1) begin @(posedge i_Clk); #1; end
      if (bus.o_rsp_valid != 2'b00) lat = k;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(e_lat));
    if (lat != 0) begin
      chk({tag, "_owner"}, 32'(bus.o_rsp_valid), 32'(2'b01 << who));
      chk({tag, "_data"},  32'(bus.o_rsp_data),  32'(e_data));
      chk({tag, "_err"},   32'(bus.o_rsp_err),   32'(e_err));
      chk({tag, "_sp"},    32'(o_sp),            32'(e_sp));
      @(posedge i_Clk); #1;
      chk({tag, "_hold"},   32'(bus.o_rsp_data), 32'(e_data));
      chk({tag, "_idle"},   32'(o_busy),         32'd0);
    end
    $display("txn %s who=%0d cmd=%0d data=%h lat=%0d rsp=%h err=%0b sp=%h",
             tag, who, cmd, data, lat, bus.o_rsp_data, bus.o_rsp_err, o_sp);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"},  32'(bus.o_req_ready), 32'd0);
    chk({tag, "_rspv"},   32'(bus.o_rsp_valid), 32'd0);
    chk({tag, "_rspd"},   32'(bus.o_rsp_data),  32'd0);
    chk({tag, "_rspe"},   32'(bus.o_rsp_err),   32'd0);
    chk({tag, "_cmd"},    32'(o_stk_command),   32'(COM_NOP));
    chk({tag, "_wdata"},  32'(o_stk_data),      32'd0);
    chk({tag, "_sp"},     32'(o_sp),            32'd0);
    chk({tag, "_busy"},   32'(o_busy),          32'd0);
  endtask

  task automatic do_reset(input string tag);
    bus.i_req_valid = 2'b11;   // ready must stay low while in reset
    bus.i_req_cmd[0] = COM_PUSH;
    bus.i_req_cmd[1] = COM_PUSH;
    i_Reset_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    bus.i_req_valid = 2'b00;
    repeat (2) @(negedge i_Clk);
    #2 i_Reset_n = 1'b1;
    sp_m = 0;
  endtask

  // Invariants checked every cycle.
  always @(negedge i_Clk) begin
    if (i_Reset_n) begin
      chk("ready_nonvalid", 32'(bus.o_req_ready & ~bus.i_req_valid), 32'd0);
      if (bus.o_rsp_valid == 2'b00) chk("err_outside_pulse", 32'(bus.o_rsp_err), 32'd0);
    end
  end

  typedef struct {
    int          who;
    logic [2:0]  cmd;
    logic [15:0] data;
    logic [15:0] e_data;
    logic        e_err;
    logic [7:0]  e_sp;
    int          e_lat;
    logic [2:0]  e_cmd;
  } vec_t;

  vec_t tbl [10];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [15:0] cur [2];
    int          sent [2];
    int          rsp_cnt [2];
    int          gq [$];
    int          gi;
    logic [15:0] e_data;
    logic        e_err;
    int          e_lat;
    logic [2:0]  e_cmd;
    logic [2:0]  rc;
    logic [15:0] rd;
    int          who;
    int          pulses;
    bit          acc;

    tbl[0] = '{0, COM_PUSH,     16'h1234, 16'h0000, 1'b0, 8'h01, 2,           COM_PUSH};
    tbl[1] = '{0, COM_PUSH,     16'hBEEF, 16'h0000, 1'b0, 8'h02, 2,           COM_PUSH};
    tbl[2] = '{1, COM_POP,      16'h0000, 16'hBEEF, 1'b0, 8'h01, 2 + POP_LAT, COM_POP};
    tbl[3] = '{1, COM_POP,      16'h0000, 16'h1234, 1'b0, 8'h00, 2 + POP_LAT, COM_POP};
    if (GUARD) tbl[4] = '{0, COM_POP, 16'h0000, 16'h0000, 1'b1, 8'h00, 2, COM_NOP};
    else       tbl[4] = '{0, COM_POP, 16'h0000, 16'h0000, 1'b0, 8'hFF, 2 + POP_LAT, COM_POP};
    tbl[5] = '{1, COM_LOAD_PTR, 16'h00FF, 16'h0000, 1'b0, 8'hFF, 2,           COM_LOAD_PTR};
    tbl[6] = '{0, COM_READ_PTR, 16'h0000, 16'h00FF, 1'b0, 8'hFF, 2,           COM_READ_PTR};
    if (GUARD) tbl[7] = '{1, COM_PUSH, 16'hAAAA, 16'h0000, 1'b1, 8'hFF, 2, COM_NOP};
    else       tbl[7] = '{1, COM_PUSH, 16'hAAAA, 16'h0000, 1'b0, 8'h00, 2, COM_PUSH};
    tbl[8] = '{0, COM_LOAD_PTR, 16'h0010, 16'h0000, 1'b0, 8'h10, 2,           COM_LOAD_PTR};
    tbl[9] = '{1, COM_READ_PTR, 16'h0000, 16'h0010, 1'b0, 8'h10, 2,           COM_READ_PTR};

    i_Reset_n       = 1'b1;
    bus.i_req_valid = 2'b00;
    bus.i_req_cmd   = '0;
    bus.i_req_data  = '0;
    #3;
    do_reset("reset0");

    // Directed table
    for (int i = 0; i < 10; i++)
      run_one($sformatf("tbl%0d", i), tbl[i].who, tbl[i].cmd, tbl[i].data,
              tbl[i].e_data, tbl[i].e_err, tbl[i].e_sp, tbl[i].e_lat, tbl[i].e_cmd);
    mem_m[0] = 16'h1234;
    mem_m[1] = 16'hBEEF;
    if (!GUARD) mem_m[255] = 16'hAAAA;

    // Round robin: both requesters stream three PUSHes each from reset
    @(posedge i_Clk); #1;
    do_reset("reset1");
    @(posedge i_Clk); #2;
    cur[0] = 16'hA000; cur[1] = 16'hB000;
    sent[0] = 0; sent[1] = 0; rsp_cnt[0] = 0; rsp_cnt[1] = 0;
    bus.i_req_cmd[0] = COM_PUSH; bus.i_req_cmd[1] = COM_PUSH;
    bus.i_req_data[0] = cur[0]; bus.i_req_data[1] = cur[1];
    bus.i_req_valid = 2'b11;
    for (int cyc = 0; cyc < 80 && (rsp_cnt[0] + rsp_cnt[1]) < 6; cyc++) begin
      @(negedge i_Clk);
      if (bus.o_rsp_valid[0]) rsp_cnt[0]++;
      if (bus.o_rsp_valid[1]) rsp_cnt[1]++;
      if (bus.o_req_ready == 2'b11) chk("rr_onehot", 32'(bus.o_req_ready), 32'd1);
      gi = -1;
      if (bus.o_req_ready[0]) gi = 0;
      else if (bus.o_req_ready[1]) gi = 1;
      if (gi >= 0) begin
        gq.push_back(gi);
        mem_m[sp_m] = cur[gi];
        sp_m = (sp_m + 1) % 256;
        $display("txn rr grant=%0d data=%h", gi, cur[gi]);
      end
      @(posedge i_Clk); #1;
      if (gi >= 0) begin
        sent[gi]++;
        if (sent[gi] < 3) begin
          cur[gi] = cur[gi] + 16'd1;
          bus.i_req_data[gi] = cur[gi];
        end else begin
          bus.i_req_valid[gi] = 1'b0;
        end
      end
    end
    bus.i_req_valid = 2'b00;
    chk("rr_grants", 32'(gq.size()), 32'd6);
    for (int i = 0; i < gq.size(); i++) chk($sformatf("rr_order%0d", i), 32'(gq[i]), 32'(i % 2));
    chk("rr_rsp0", 32'(rsp_cnt[0]), 32'd3);
    chk("rr_rsp1", 32'(rsp_cnt[1]), 32'd3);
    @(negedge i_Clk);
    chk("rr_sp", 32'(o_sp), 32'(sp_m));

    // Reset while a POP sits in WAIT
    model_step(COM_PUSH, 16'h7777, e_data, e_err, e_lat, e_cmd);
    run_one("pre_pop", 0, COM_PUSH, 16'h7777, e_data, e_err, 8'(sp_m), e_lat, e_cmd);
    @(posedge i_Clk); #2;
    bus.i_req_valid[1] = 1'b1; bus.i_req_cmd[1] = COM_POP; bus.i_req_data[1] = 16'h0;
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge i_Clk);
      if (bus.o_req_ready[1]) acc = 1'b1;
    end
    chk("rstw_accept", 32'(acc), 32'd1);
    @(posedge i_Clk); #1;
    bus.i_req_valid[1] = 1'b0;
    chk("rstw_issue", 32'(o_stk_command), 32'(COM_POP));
    @(posedge i_Clk); #1;
    chk("rstw_wait_busy", 32'(o_busy), 32'd1);
    chk("rstw_wait_nop", 32'(o_stk_command), 32'(COM_NOP));
    do_reset("rstw");
    pulses = 0;
    repeat (4) begin
      @(negedge i_Clk);
      if (bus.o_rsp_valid != 2'b00) pulses++;
    end
    chk("rstw_no_rsp", 32'(pulses), 32'd0);
    $display("txn reset_in_wait pulses=%0d", pulses);
    model_step(COM_PUSH, 16'h5555, e_data, e_err, e_lat, e_cmd);
    run_one("post_rst", 1, COM_PUSH, 16'h5555, e_data, e_err, 8'(sp_m), e_lat, e_cmd);

    // Randomized traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      who = int'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: rc = COM_PUSH;
        1: rc = COM_POP;
        2: rc = COM_LOAD_PTR;
        default: rc = COM_READ_PTR;
      endcase
      rd = 16'($urandom);
      if (rc == COM_LOAD_PTR) begin
        case ($urandom_range(0, 4))
          0: rd = 16'h0000;
          1: rd = 16'h00FF;
          2: rd = 16'h0001;
          3: rd = 16'h00FE;
          default: ;
        endcase
      end
      model_step(rc, rd, e_data, e_err, e_lat, e_cmd);
      run_one($sformatf("rnd%0d", i), who, rc, rd, e_data, e_err, 8'(sp_m), e_lat, e_cmd);
    end

    repeat (2) @(posedge i_Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
